// File: rtl/io_fifo_port.sv
// io_fifo_port: I/O-mapped byte FIFO on the demultiplexed 8088 min-mode bus.
// OUT to port 0 pushes a byte. IN returns STATUS (port 0) or COUNT (port 1).
// OUT to port 2 is CTRL (flush / clear overflow).
// A valid/ready stream drains the FIFO head to a downstream consumer.
module io_fifo_port #(
  parameter int   ADDRESSWIDTH = 16,
  parameter logic IS_IO        = 1'b1,
  parameter int   DEPTH        = 8
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    CS,
  input  logic                    ALE,
  input  logic                    IOM,
  input  logic                    WR,
  input  logic                    RD,
  input  logic [ADDRESSWIDTH-1:0] Address,
  inout  wire  [7:0]              Data,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int             PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]  LAST   = PW'(DEPTH - 1);
  localparam logic [3:0]     DEPTH4 = 4'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARM   = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] READ  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  sel_q, sel_d;
  logic [1:0]            off_q, off_d;
  logic [7:0]            wbuf_q, wbuf_d;
  logic [7:0]            rbuf_q, rbuf_d;
  logic                  commit;

  logic [DEPTH-1:0][7:0] mem_q;
  logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
  logic [3:0]            cnt_q;
  logic                  ovf_q;

  logic                  full, empty, pop, push, ctrl, do_push;
  logic [7:0]            reg_rd;

  // Only the low two address bits are decoded.
  logic unused_addr;
  assign unused_addr = ^Address[ADDRESSWIDTH-1:2];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign full      = (cnt_q == DEPTH4);
  assign empty     = (cnt_q == 4'd0);
  assign out_valid = !empty;
  assign out_data  = mem_q[rd_ptr_q];
  assign pop       = out_valid & out_ready;
  assign push      = commit && (off_q == 2'd0);
  assign ctrl      = commit && (off_q == 2'd2);
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign do_push   = push && (!full || pop);

  // Data is only driven while our own IN strobe is active.
  assign Data = (state_q == READ && !RD) ? rbuf_q : 8'hzz;

  // Register read mux, sampled into rbuf once at the start of an IN strobe.
  always_comb begin
    reg_rd = 8'h00;
    case (off_q)
      2'd0:    reg_rd = {cnt_q, 1'b0, ovf_q, full, empty};
      2'd1:    reg_rd = {4'b0000, cnt_q};
      default: reg_rd = 8'h00;
    endcase
  end

  // Bus FSM next state; ALE always restarts decode from IDLE.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    off_d   = off_q;
    wbuf_d  = wbuf_q;
    rbuf_d  = rbuf_q;
    commit  = 1'b0;
    if (ALE) begin
      sel_d   = CS & (IOM == IS_IO);
      off_d   = Address[1:0];
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (sel_q) begin
          state_d = ARM;
          sel_d   = 1'b0;   // consume the selection so one ALE yields one cycle
        end
        ARM: if (!WR) begin
          state_d = WRITE;
          wbuf_d  = Data;
        end else if (!RD) begin
          state_d = READ;
          rbuf_d  = reg_rd;
        end
        WRITE: if (!WR) begin
          wbuf_d  = Data;
        end else begin
          commit  = 1'b1;
          state_d = IDLE;
        end
        READ: if (RD) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Bus FSM state registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      off_q   <= 2'd0;
      wbuf_q  <= 8'h00;
      rbuf_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      off_q   <= off_d;
      wbuf_q  <= wbuf_d;
      rbuf_q  <= rbuf_d;
    end
  end

  // FIFO storage, pointers and count; flush beats a same-edge pop.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= 4'd0;
    end else if (ctrl && wbuf_q[0]) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= 4'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wbuf_q;
        wr_ptr_q        <= nxt(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= nxt(rd_ptr_q);
      cnt_q <= cnt_q + 4'(do_push) - 4'(pop);
    end
  end

  // Sticky overflow flag, cleared only by CTRL bit1.
  always_ff @(posedge CLK) begin
    if (RESET)                     ovf_q <= 1'b0;
    else if (ctrl && wbuf_q[1])    ovf_q <= 1'b0;
    else if (push && full && !pop) ovf_q <= 1'b1;
  end

endmodule

// File: tb/tb_io_fifo_port.sv
// Directed bench for io_fifo_port: a vector table for basic register
// accesses plus hand-written sequences for overflow, flush, read snapshot,
// reset abort and a randomised-ready ordering run.
module tb_io_fifo_port;

  logic        CLK = 1'b0;
  logic        RESET, CS, ALE, IOM, WR, RD;
  logic [15:0] Address;
  tri1  [7:0]  Data;          // released bus reads back as 8'hFF
  logic [7:0]  out_data;
  logic        out_valid, out_ready;

  logic        den;
  logic [7:0]  dout;
  logic        tb_ready, rnd_ready, stress_on;
  logic [7:0]  rdv;
  logic [7:0]  exp_q[$];

  int total = 0;
  int passed = 0;

  assign Data      = den ? dout : 8'hzz;
  assign out_ready = stress_on ? rnd_ready : tb_ready;

  always #5 CLK = ~CLK;

  io_fifo_port #(.ADDRESSWIDTH(16), .IS_IO(1'b1), .DEPTH(8)) dut (
    .CLK(CLK), .RESET(RESET), .CS(CS), .ALE(ALE), .IOM(IOM), .WR(WR), .RD(RD),
    .Address(Address), .Data(Data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] off, input logic [7:0] d,
                           input logic cs, input logic iom, input logic rdy);
    ALE = 1'b1; CS = cs; IOM = iom; Address = {14'h0, off};
    tick;
    ALE = 1'b0;
    tick;
    WR = 1'b0; den = 1'b1; dout = d;
    tick;
    tick;
    WR = 1'b1;
    if (rdy) tb_ready = 1'b1;
    tick;                      // commit edge
    den = 1'b0; tb_ready = 1'b0; CS = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] off, input logic cs, input logic iom,
                          output logic [7:0] d);
    ALE = 1'b1; CS = cs; IOM = iom; Address = {14'h0, off};
    tick;
    ALE = 1'b0;
    tick;
    RD = 1'b0;
    tick;                      // snapshot edge
    tick;
    d = Data;
    RD = 1'b1;
    tick;
    CS = 1'b0;
  endtask

  task automatic wr0(input logic [7:0] d);
    bus_write(2'd0, d, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic rd_chk(input string name, input logic [1:0] off, input logic [7:0] exp);
    logic [7:0] v;
    bus_read(off, 1'b1, 1'b1, v);
    chk(name, v, exp);
  endtask

  task automatic pop_chk(input logic [7:0] exp);
    chk("head valid", {7'h0, out_valid}, 8'h01);
    chk("head data", out_data, exp);
    tb_ready = 1'b1;
    tick;
    tb_ready = 1'b0;
  endtask

  // Random-ready consumer: decides at negedge, so the pop lands on the next posedge.
  always @(negedge CLK) begin
    if (stress_on) begin
      rnd_ready = 1'($urandom_range(0, 1));
      if (out_valid && rnd_ready) begin
        if (exp_q.size() == 0) chk("stress extra pop", out_data, 8'hxx);
        else chk("stress order", out_data, exp_q.pop_front());
      end
    end
  end

  typedef struct {
    int         op;     // 0 write, 1 read-check, 2 pop-check
    logic [1:0] off;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{0, 2'd0, 8'hA5, 8'h00};
    tbl[1] = '{1, 2'd1, 8'h00, 8'h01};
    tbl[2] = '{1, 2'd0, 8'h00, 8'h10};
    tbl[3] = '{1, 2'd3, 8'h00, 8'h00};
    tbl[4] = '{0, 2'd3, 8'hFF, 8'h00};
    tbl[5] = '{0, 2'd1, 8'hEE, 8'h00};
    tbl[6] = '{1, 2'd1, 8'h00, 8'h01};
    tbl[7] = '{2, 2'd0, 8'h00, 8'hA5};
    tbl[8] = '{1, 2'd0, 8'h00, 8'h01};
    tbl[9] = '{1, 2'd2, 8'h00, 8'h00};

    RESET = 1'b1; CS = 1'b0; ALE = 1'b0; IOM = 1'b0; WR = 1'b1; RD = 1'b1;
    Address = 16'h0; den = 1'b0; dout = 8'h00; tb_ready = 1'b0;
    rnd_ready = 1'b0; stress_on = 1'b0;
    tick; tick;
    RESET = 1'b0;
    tick;
    chk("reset out_valid", {7'h0, out_valid}, 8'h00);
    chk("reset out_data", out_data, 8'h00);
    chk("reset bus released", Data, 8'hFF);

    // Basic register map.
    for (int i = 0; i < 10; i++) begin
      case (tbl[i].op)
        0: bus_write(tbl[i].off, tbl[i].d, 1'b1, 1'b1, 1'b0);
        1: rd_chk($sformatf("vec%0d read", i), tbl[i].off, tbl[i].exp);
        default: pop_chk(tbl[i].exp);
      endcase
    end

    // Overflow: ninth byte is dropped, ovf sticks.
    for (int i = 1; i <= 9; i++) wr0(8'(i));
    rd_chk("ovf status", 2'd0, 8'h86);
    for (int i = 1; i <= 8; i++) pop_chk(8'(i));
    chk("drained", {7'h0, out_valid}, 8'h00);
    rd_chk("ovf sticky", 2'd0, 8'h05);
    bus_write(2'd2, 8'h02, 1'b1, 1'b1, 1'b0);
    rd_chk("ovf cleared", 2'd0, 8'h01);

    // Push into a full FIFO on the same edge as a pop.
    for (int i = 0; i < 8; i++) wr0(8'h10 + 8'(i));
    rd_chk("full status", 2'd0, 8'h82);
    bus_write(2'd0, 8'h55, 1'b1, 1'b1, 1'b1);
    rd_chk("full push+pop", 2'd0, 8'h82);
    for (int i = 1; i < 8; i++) pop_chk(8'h10 + 8'(i));
    pop_chk(8'h55);

    // Flush + ovf clear with 5 entries.
    for (int i = 0; i < 9; i++) wr0(8'h21 + 8'(i));
    pop_chk(8'h21); pop_chk(8'h22); pop_chk(8'h23);
    rd_chk("pre-flush status", 2'd0, 8'h54);
    bus_write(2'd2, 8'h03, 1'b1, 1'b1, 1'b0);
    chk("flush out_valid", {7'h0, out_valid}, 8'h00);
    rd_chk("post-flush status", 2'd0, 8'h01);

    // IN snapshot holds while the consumer pops under the strobe.
    wr0(8'hA1); wr0(8'hA2); wr0(8'hA3);
    ALE = 1'b1; CS = 1'b1; IOM = 1'b1; Address = 16'h0;
    tick;
    ALE = 1'b0;
    tick;
    chk("pre-strobe released", Data, 8'hFF);
    RD = 1'b0;
    tick;
    tb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("snapshot stable", Data, 8'h30);
    end
    RD = 1'b1; tb_ready = 1'b0;
    tick;
    CS = 1'b0;
    chk("post-strobe released", Data, 8'hFF);
    chk("popped during read", {7'h0, out_valid}, 8'h00);

    // Unselected cycles: no push, no drive.
    bus_write(2'd0, 8'h99, 1'b0, 1'b1, 1'b0);
    bus_write(2'd0, 8'h98, 1'b1, 1'b0, 1'b0);
    chk("unselected no push", {7'h0, out_valid}, 8'h00);
    bus_read(2'd0, 1'b0, 1'b1, rdv);
    chk("cs=0 not driven", rdv, 8'hFF);
    bus_read(2'd1, 1'b1, 1'b0, rdv);
    chk("mem cycle not driven", rdv, 8'hFF);

    // Reset in the middle of a write aborts the commit.
    ALE = 1'b1; CS = 1'b1; IOM = 1'b1; Address = 16'h0;
    tick;
    ALE = 1'b0;
    tick;
    WR = 1'b0; den = 1'b1; dout = 8'h77;
    tick;
    tick;
    RESET = 1'b1;
    tick;
    RESET = 1'b0; WR = 1'b1; den = 1'b0; CS = 1'b0;
    tick;
    tick;
    chk("reset abort no push", {7'h0, out_valid}, 8'h00);
    chk("reset abort released", Data, 8'hFF);
    rd_chk("reset abort count", 2'd1, 8'h00);

    // Ordering with random backpressure across pointer wrap.
    stress_on = 1'b1;
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(8'hC0 + 8'(i));
      wr0(8'hC0 + 8'(i));
    end
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
        tick;
        n++;
      end
      if (exp_q.size() != 0) chk("stress drain timeout", 8'(exp_q.size()), 8'h00);
    end
    stress_on = 1'b0;
    tick;
    chk("stress empty", {7'h0, out_valid}, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/io_fifo_port.md
# io_fifo_port

I/O-mapped byte FIFO peripheral on the demultiplexed 8088 minimum-mode bus. It sits downstream of the address latch, data transceiver and chip-select decode, alongside the IO/memory models. OUT cycles to its ports push bytes into a FIFO, and IN cycles return status and count. A valid/ready stream drains the FIFO to a downstream consumer, such as a serial or display model.

## Interface
- ADDRESSWIDTH, 16, width of the `Address` input; only bits [1:0] are decoded.
- IS_IO, 1'b1, value of `IOM` that selects this block.
- DEPTH, 8, number of FIFO entries; legal range 2..15.
- CLK  in  1  system clock; all state changes on its rising edge.
- RESET  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- CS  in  1  chip select from the external decode.
- ALE  in  1  address latch enable from the CPU.
- IOM  in  1  IO/memory status.
- WR  in  1  write strobe, active low.
- RD  in  1  read strobe, active low.
- Address  in  ADDRESSWIDTH  latched bus address.
- Data  inout  8  demultiplexed data bus; this block drives it only during its own read cycles, otherwise `'z`.
- out_data  out  8  FIFO head byte.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts `out_data` when it is high together with `out_valid`.

## Operation
**Register map (by `Address[1:0]`)**
- 0 write: push `Data` into the FIFO.
- 0 read: STATUS = {count[3:0], 1'b0, ovf, full, empty}.
- 1 read: COUNT, zero-extended to 8 bits.
- 2 write: CTRL. bit0 = 1 flushes the FIFO. bit1 = 1 clears `ovf`. Other bits are ignored.
- All other accesses: writes are ignored; reads return 8'h00 (bus is still driven).

**Bus FSM states: IDLE, ARM, WRITE, READ**
- Any state: while `ALE` is high, capture `sel = CS & (IOM==IS_IO)` and `off = Address[1:0]` every clock; the state becomes IDLE. The last capture before `ALE` falls wins.
- IDLE → ARM: on the first clock with `ALE` low and `sel` = 1. If `sel` = 0, stay in IDLE.
- ARM → WRITE: when `WR` is sampled low.
- ARM → READ: when `RD` is sampled low.
- If both strobes are low, WRITE takes priority.
- WRITE:
  - Register `Data` into `wbuf` on every clock where `WR` is low.
  - On the first clock `WR` is sampled high, commit `wbuf` to `off`, then go to IDLE.
- READ:
  - On entry, snapshot the selected register into `rbuf`.
  - Drive `Data = rbuf` while in READ and `RD` is low.
  - On `RD` sampled high, go to IDLE and stop driving.

**FIFO**
- Circular buffer of DEPTH bytes with a wrapping read pointer, write pointer and count (0..DEPTH).
- pop = `out_valid & out_ready`; push = committed write to offset 0.
- Push when full with no pop in the same clock: the byte is dropped and `ovf` is set. `ovf` is sticky.
- Push and pop in the same clock: both are performed, including when full; count is unchanged.
- Flush: sets count and both pointers to 0. A flush in the same clock as a pop wins.
- `out_data` = mem[rd_ptr]; `out_valid` = (count != 0).

## Timing
- Reset values: state = IDLE, count = 0, pointers = 0, `ovf` = 0, `out_valid` = 0, `out_data` = 8'h00 or don't-care (8'h00 preferred), `Data` = `'z`.
- Reset mid-cycle aborts any bus cycle; a pending commit is discarded.
- Write latency:
  - Edge where `WR` is sampled high = commit edge.
  - `out_valid` and COUNT reflect the push one clock after the commit edge (registered).
- Read latency:
  - `rbuf` is loaded on the edge where `RD` is first sampled low.
  - `Data` is driven from the next clock until `RD` is sampled high.
  - The value is stable for the whole strobe; pops during the strobe do not alter it.
- Pop: the consumer sees the next head on the clock after the accepting edge.
- `out_data` must stay stable while `out_valid` is high and `out_ready` is low.
- Pointer wrap: DEPTH−1 → 0.
- Count uses a 4-bit counter; arithmetic never exceeds DEPTH or goes below 0.

## Test plan
- Reset, then OUT 8'hA5 to port 0 with `out_ready` = 0 → COUNT reads 1, STATUS = 8'h10, `out_data` = 8'hA5.
- 9 OUTs of 8'h01..8'h09 with DEPTH = 8 and `out_ready` = 0 → STATUS = 8'h86 (count = 8, full, ovf); the drain then yields 01..08 in order and 09 is lost.
- Full FIFO, `out_ready` held at 1, OUT 8'h55 whose commit edge coincides with a pop → count stays 8 and `ovf` stays 0.
- CTRL write of 8'h03 with 5 entries and `ovf` set → count = 0, STATUS = 8'h01, `out_valid` = 0 on the next clock.
- IN from port 0 while `out_ready` pops during the `RD` strobe → `Data` holds the snapshot value for the full strobe and is `'z` outside it. A cycle with `CS` = 0 or `IOM` ≠ IS_IO is never driven and never pushed.
- `RESET` asserted mid-WRITE after `WR` falls with 8'h77 on the bus → nothing is pushed; after reset, count = 0 and `Data` = `'z`.
- Wrap stress: 20 push/pop pairs alternating with random `out_ready` → output order matches input exactly.
